// File: rtl/e_muldiv_unit_pkg.sv
// Shared MD op codes, state encoding and request payload for the E-stage multiply/divide unit.
// The E-stage decoder reuses the md_op_e codes.
package e_muldiv_unit_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned MD_OP_W = 4;

    typedef enum logic [MD_OP_W-1:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MADD  = 4'd7,
        MD_MADDU = 4'd8,
        MD_MSUB  = 4'd9,
        MD_MSUBU = 4'd10
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    // Operands and op captured when a multi-cycle operation starts
    typedef struct packed {
        md_op_e            op;
        logic [XLEN-1:0]   a;
        logic [XLEN-1:0]   b;
    } md_req_t;

    // True for ops whose operands are interpreted as two's complement
    function automatic logic is_signed_op(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD) || (op == MD_MSUB);
    endfunction

    // Widen an operand to 64 bits, sign- or zero-extending
    function automatic logic [2*XLEN-1:0] ext64(input logic [XLEN-1:0] x, input logic sgn);
        return sgn ? {{XLEN{x[XLEN-1]}}, x} : {{XLEN{1'b0}}, x};
    endfunction

endpackage

// File: rtl/e_muldiv_unit_if.sv
// E-stage <-> multiply/divide unit connection: start/op/operands in, busy/hold/HI/LO out.
interface e_muldiv_unit_if;
    import e_muldiv_unit_pkg::*;

    logic                 in_start;
    logic [MD_OP_W-1:0]   in_op;
    logic [XLEN-1:0]      in_a;
    logic [XLEN-1:0]      in_b;
    logic                 out_busy;
    logic                 out_hold;
    logic [XLEN-1:0]      out_hi;
    logic [XLEN-1:0]      out_lo;

    modport master (
        output in_start, in_op, in_a, in_b,
        input  out_busy, out_hold, out_hi, out_lo
    );

    modport slave (
        input  in_start, in_op, in_a, in_b,
        output out_busy, out_hold, out_hi, out_lo
    );

endinterface

// File: rtl/e_muldiv_unit.sv
// E-stage multiply/divide unit owning HI/LO. Multi-cycle latency is modelled by a busy counter;
// the result is computed combinationally from latched operands and committed as busy drops.
// Optional feature macro: MDU_MADD_EN (adds MADD/MADDU/MSUB/MSUBU accumulate ops).
module e_muldiv_unit
    import e_muldiv_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic            clk,
    input  logic            reset,
    e_muldiv_unit_if.slave  md
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam int unsigned DW         = 2 * XLEN;

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    md_req_t            req_q, req_d;
    logic [XLEN-1:0]    hi_q, hi_d, lo_q, lo_d;

    md_op_e             op_in;
    logic               sgn;
    logic [DW-1:0]      prod;
    logic               a_neg, b_neg;
    logic [XLEN-1:0]    a_mag, b_mag, div_by, q_mag, r_mag, quo, rem;
    logic               res_we;
    logic [DW-1:0]      res;

    assign op_in = md_op_e'(md.in_op);

    // Product and quotient/remainder from the latched operands
    always_comb begin
        sgn    = is_signed_op(req_q.op);
        prod   = DW'(ext64(req_q.a, sgn) * ext64(req_q.b, sgn));
        a_neg  = sgn & req_q.a[XLEN-1];
        b_neg  = sgn & req_q.b[XLEN-1];
        a_mag  = a_neg ? XLEN'(-req_q.a) : req_q.a;
        b_mag  = b_neg ? XLEN'(-req_q.b) : req_q.b;
        // Divisor forced non-zero so the divider never sees /0; that result is discarded anyway
        div_by = (b_mag == '0) ? XLEN'(1) : b_mag;
        q_mag  = a_mag / div_by;
        r_mag  = a_mag % div_by;
        quo    = (a_neg ^ b_neg) ? XLEN'(-q_mag) : q_mag;
        rem    = a_neg ? XLEN'(-r_mag) : r_mag;
    end

    // Commit mux: which {HI,LO} value the finishing op writes, if any
    always_comb begin
        res_we = 1'b0;
        res    = {hi_q, lo_q};
        case (req_q.op)
            MD_MULT, MD_MULTU: begin
                res_we = 1'b1;
                res    = prod;
            end
            MD_DIV, MD_DIVU: begin
                res_we = (req_q.b != '0);
                res    = {rem, quo};
            end
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU: begin
                res_we = 1'b1;
                res    = DW'({hi_q, lo_q} + prod);
            end
            MD_MSUB, MD_MSUBU: begin
                res_we = 1'b1;
                res    = DW'({hi_q, lo_q} - prod);
            end
`endif
            default: ;
        endcase
    end

    // Next-state: start/MT handling while idle, countdown and commit while busy
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (md.in_start) begin
                    case (op_in)
                        MD_MULT, MD_MULTU: begin
                            state_d = ST_BUSY;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            req_d   = '{op: op_in, a: md.in_a, b: md.in_b};
                        end
`ifdef MDU_MADD_EN
                        MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: begin
                            state_d = ST_BUSY;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            req_d   = '{op: op_in, a: md.in_a, b: md.in_b};
                        end
`endif
                        MD_DIV, MD_DIVU: begin
                            state_d = ST_BUSY;
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            req_d   = '{op: op_in, a: md.in_a, b: md.in_b};
                        end
                        MD_MTHI: hi_d = md.in_a;
                        MD_MTLO: lo_d = md.in_a;
                        default: ;
                    endcase
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    if (res_we) begin
                        hi_d = res[DW-1:XLEN];
                        lo_d = res[XLEN-1:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counter, operand latches and HI/LO; reset aborts any op in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Flag a start that the hazard unit should have stalled; it is ignored
    always_ff @(posedge clk) begin
        if (!reset && md.in_start && (state_q == ST_BUSY))
            $warning("e_muldiv_unit: in_start while busy ignored (op %0d)", md.in_op);
    end

    assign md.out_busy = (state_q == ST_BUSY);
    assign md.out_hold = md.in_start | md.out_busy;
    assign md.out_hi   = hi_q;
    assign md.out_lo   = lo_q;

endmodule

// File: tb/tb_e_muldiv_unit.sv
// Scoreboard bench for e_muldiv_unit: driver pushes reference-model results, negedge monitor
// pops and compares when each operation completes. Honours MDU_MADD_EN like the design.
module tb_e_muldiv_unit;
    import e_muldiv_unit_pkg::*;

    localparam int unsigned MULT_N = 5;
    localparam int unsigned DIV_N  = 10;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    e_muldiv_unit_if mif();

    e_muldiv_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (mif)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        sb[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural reference: plain 64-bit arithmetic on HI/LO
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sb_, ua, ub, q, r;
        logic [63:0] acc;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        acc = {m_hi, m_lo};
        e.cycles = 0;
        case (op)
            MD_MULT:  begin acc = 64'(sa * sb_); e.cycles = MULT_N; end
            MD_MULTU: begin acc = 64'({32'b0, a}) * 64'({32'b0, b}); e.cycles = MULT_N; end
            MD_DIV, MD_DIVU: begin
                e.cycles = DIV_N;
                if (b != 0) begin
                    q = (op == MD_DIV) ? sa / sb_ : ua / ub;
                    r = (op == MD_DIV) ? sa % sb_ : ua % ub;
                    acc = {r[31:0], q[31:0]};
                end
            end
            MD_MTHI:  acc[63:32] = a;
            MD_MTLO:  acc[31:0]  = a;
`ifdef MDU_MADD_EN
            MD_MADD:  begin acc = acc + 64'(sa * sb_); e.cycles = MULT_N; end
            MD_MSUB:  begin acc = acc - 64'(sa * sb_); e.cycles = MULT_N; end
            MD_MADDU: begin acc = acc + 64'({32'b0, a}) * 64'({32'b0, b}); e.cycles = MULT_N; end
            MD_MSUBU: begin acc = acc - 64'({32'b0, a}) * 64'({32'b0, b}); e.cycles = MULT_N; end
`endif
            default: ;
        endcase
        m_hi = acc[63:32];
        m_lo = acc[31:0];
        e.hi = m_hi;
        e.lo = m_lo;
        return e;
    endfunction

    // Drive one start cycle, scramble operands, then wait (bounded) for busy to clear
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        sb.push_back(model(op, a, b));
        @(posedge clk); #1;
        mif.in_start = 1'b1;
        mif.in_op    = op;
        mif.in_a     = a;
        mif.in_b     = b;
        @(posedge clk); #1;
        mif.in_start = 1'b0;
        mif.in_a     = $urandom;
        mif.in_b     = $urandom;
        n = 0;
        while (mif.out_busy && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 60) begin
            n_checks++;
            n_fail++;
            $display("FAIL busy_timeout: busy still %b after %0d cycles, required 0", mif.out_busy, n);
        end
    endtask

    function automatic logic [31:0] rnd_opnd();
        logic [31:0] edges[5];
        edges = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return edges[$urandom_range(0, 4)];
            2:       return 32'($urandom_range(0, 20));
            default: return 32'(0 - $urandom_range(0, 20));
        endcase
    endfunction

    // Monitor: count busy cycles, check HI/LO hold while busy, compare against scoreboard on completion
    logic        pending = 1'b0;
    int          cyc     = 0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            pending = 1'b0;
            last_hi = '0;
            last_lo = '0;
        end else begin
            if (pending) begin
                if (mif.out_busy) begin
                    cyc++;
                    check32("hi_held_while_busy", mif.out_hi, last_hi);
                    check32("lo_held_while_busy", mif.out_lo, last_lo);
                    if (cyc > 40) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL monitor_timeout: busy for %0d cycles, required at most %0d", cyc, DIV_N);
                        pending = 1'b0;
                        if (sb.size() > 0) void'(sb.pop_front());
                    end
                end else begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL sb_empty: completion seen with 0 entries, required 1");
                    end else begin
                        e = sb.pop_front();
                        check32("busy_cycles", 32'(cyc), 32'(e.cycles));
                        check32("hi", mif.out_hi, e.hi);
                        check32("lo", mif.out_lo, e.lo);
                        last_hi = e.hi;
                        last_lo = e.lo;
                    end
                    pending = 1'b0;
                end
            end
            if (mif.in_start && !mif.out_busy) begin
                check32("hold_on_start", 32'(mif.out_hold), 32'd1);
                pending = 1'b1;
                cyc     = 0;
            end
        end
    end

    initial begin
        logic [3:0] ops[13];
        ops = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, MD_MADD,
                MD_MADDU, MD_MSUB, MD_MSUBU, MD_NONE, 4'd13, 4'd15};
        mif.in_start = 1'b0;
        mif.in_op    = '0;
        mif.in_a     = '0;
        mif.in_b     = '0;
        reset        = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check32("rst_busy", 32'(mif.out_busy), 32'd0);
        check32("rst_hold", 32'(mif.out_hold), 32'd0);
        check32("rst_hi", mif.out_hi, 32'h0);
        check32("rst_lo", mif.out_lo, 32'h0);

        issue(MD_MULT, 32'hFFFFFFFE, 32'd3);
        check32("mult_neg_hi", mif.out_hi, 32'hFFFFFFFF);
        check32("mult_neg_lo", mif.out_lo, 32'hFFFFFFFA);

        issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check32("multu_max_hi", mif.out_hi, 32'hFFFFFFFE);
        check32("multu_max_lo", mif.out_lo, 32'h00000001);

        issue(MD_DIV, 32'hFFFFFFF9, 32'd2);
        check32("div_neg_hi", mif.out_hi, 32'hFFFFFFFF);
        check32("div_neg_lo", mif.out_lo, 32'hFFFFFFFD);

        issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
        check32("div_ovf_hi", mif.out_hi, 32'h0);
        check32("div_ovf_lo", mif.out_lo, 32'h80000000);

        issue(MD_MTHI, 32'h11, 32'h0);
        issue(MD_MTLO, 32'h22, 32'h0);
        issue(MD_DIVU, 32'd5, 32'd0);
        check32("divz_hi", mif.out_hi, 32'h11);
        check32("divz_lo", mif.out_lo, 32'h22);

        issue(MD_NONE, 32'h1234, 32'h5678);
        issue(4'd15, 32'h1234, 32'h5678);
        check32("other_op_hi", mif.out_hi, 32'h11);

        // Reset during the third busy cycle of a MULT aborts it
        @(posedge clk); #1;
        mif.in_start = 1'b1;
        mif.in_op    = MD_MULT;
        mif.in_a     = 32'd9;
        mif.in_b     = 32'd9;
        @(posedge clk); #1;
        mif.in_start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_hi  = '0;
        m_lo  = '0;
        check32("abort_busy", 32'(mif.out_busy), 32'd0);
        check32("abort_hi", mif.out_hi, 32'h0);
        check32("abort_lo", mif.out_lo, 32'h0);
        issue(MD_MULT, 32'd7, 32'd6);
        check32("restart_lo", mif.out_lo, 32'd42);

        issue(MD_MTHI, 32'h0, 32'h0);
        issue(MD_MTLO, 32'd10, 32'h0);
        issue(MD_MADD, 32'hFFFFFFFF, 32'd4);
        check32("madd_hi", mif.out_hi, 32'h0);
`ifdef MDU_MADD_EN
        check32("madd_lo", mif.out_lo, 32'd6);
`else
        check32("madd_lo", mif.out_lo, 32'd10);
`endif

        for (int i = 0; i < 150; i++) begin
            issue(ops[$urandom_range(0, 12)], rnd_opnd(), ($urandom_range(0, 7) == 0) ? 32'h0 : rnd_opnd());
        end

        repeat (3) @(negedge clk);
        check32("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
